multicycle_controller: RTL and testbench

- Main FSM that sequences the shared-ALU, shared-memory multicycle RV32I datapath. This is the next revision of the single-cycle core.
- Each cycle it drives every datapath enable and mux select from the latched instruction fields (opcode, func3, func7) and the ALU zero flag.
- Supported subset: add, sub, and, or, slt, addi, xori, ori, slti, lw, sw, beq, bne, blt, bge, jal, jalr, lui.

---
 rtl/riscv_mc_pkg.sv | 90 +++++++++
 rtl/mc_alu_decoder.sv | 44 ++++
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared constants for the multicycle RV32I controller
//
// Purpose: state encoding, opcode constants, datapath select codes and the
// instruction legality check used by multicycle_controller.
// Ports: none (package).
package riscv_mc_pkg;

  // FSM state encoding (4 bits, also exported on state_dbg)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JALRLINK = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RFUNC  = 2'b10;
  localparam logic [1:0] ALUOP_IFUNC  = 2'b11;

  // True when the encoding belongs to the supported RV32I subset.
  function automatic logic legal_instr(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: ok = 1'b1;
      OP_RTYPE: begin
        if (f7 == 7'b0100000)
          ok = (f3 == 3'b000);
        else if (f7 == 7'b0000000)
          ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
        else
          ok = 1'b0;
      end
      // addi/slti/xori/ori all have func3[0] clear
      OP_IALU:   ok = (f3[0] == 1'b0);
      // beq/bne/blt/bge all have func3[1] clear
      OP_BRANCH: ok = (f3[1] == 1'b0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational ALUControl decode
//
// Purpose: maps the FSM's ALU operation class plus func3/func7 to ALUControl.
// Ports:
//   alu_op      in  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
//   func3       in  3  instruction[14:12]
//   func7       in  7  instruction[31:25]
//   alu_control out 3  ALU operation code
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      // blt/bge (func3[2]=1) compare with slt; beq/bne subtract and test zero
      ALUOP_BRANCH: alu_control = func3[2] ? ALU_SLT : ALU_SUB;
      ALUOP_RFUNC: begin
        case (func3)
          3'b000:  alu_control = (func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      ALUOP_IFUNC: begin
        case (func3)
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main FSM of the multicycle RV32I datapath
//
// Purpose: sequences the shared ALU and unified memory, driving every
// datapath enable and select from the latched instruction fields.
// Ports:
//   clk, rst (async active-low)
//   opcode/func3/func7 in   instruction fields from the IR
//   zero               in   ALU zero flag, current cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite          out  enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc       out  mux/ALU codes
//   instr_done  out  pulse in the last state of each instruction
//   illegal     out  sticky unsupported-encoding flag
//   state_dbg   out  current state encoding
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  logic [3:0] state, state_next;
  logic       illegal_q;

  logic       pc_write_d, adr_src_d, mem_write_d, ir_write_d, reg_write_d, instr_done_d;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, alu_op;
  logic [2:0] imm_src_d, alu_control_d;
  logic       branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (!legal_instr(opcode, func3, func7)) begin
          state_next = S_ILLEGAL;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_RTYPE:          state_next = S_EXECR;
            OP_IALU:           state_next = S_EXECI;
            OP_BRANCH:         state_next = S_BRANCH;
            OP_JAL:            state_next = S_JAL;
            OP_JALR:           state_next = S_JALR;
            OP_LUI:            state_next = S_LUI;
            default:           state_next = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR:  state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_next = S_MEMWB;
      S_JALR:    state_next = S_JALRLINK;
      S_EXECR, S_EXECI, S_JAL, S_JALRLINK: state_next = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI: state_next = S_FETCH;
      S_ILLEGAL: state_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // beq/bge take on zero, bne/blt on !zero: func3[0]^func3[2] flips the sense
  assign branch_taken = zero ^ func3[0] ^ func3[2];

  always_comb begin
    pc_write_d   = 1'b0;
    adr_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    instr_done_d = 1'b0;
    result_src_d = RES_ALUOUT;
    alu_src_a_d  = SRCA_PC;
    alu_src_b_d  = SRCB_B;
    imm_src_d    = IMM_I;
    alu_op       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_d   = 1'b1;
        pc_write_d   = 1'b1;
        alu_src_b_d  = SRCB_FOUR;
        result_src_d = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a_d = SRCA_OLDPC;
        alu_src_b_d = SRCB_IMM;
        imm_src_d   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a_d = SRCA_A;
        alu_src_b_d = SRCB_IMM;
        imm_src_d   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src_d = 1'b1;
      S_MEMWB: begin
        result_src_d = RES_DATA;
        reg_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_d    = 1'b1;
        mem_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_d = SRCA_A;
        alu_op      = ALUOP_RFUNC;
      end
      S_EXECI: begin
        alu_src_a_d = SRCA_A;
        alu_src_b_d = SRCB_IMM;
        alu_op      = ALUOP_IFUNC;
      end
      S_ALUWB: begin
        reg_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      S_JAL: begin
        alu_src_a_d = SRCA_OLDPC;
        alu_src_b_d = SRCB_FOUR;
        pc_write_d  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_d  = SRCA_A;
        alu_src_b_d  = SRCB_IMM;
        result_src_d = RES_ALURESULT;
        pc_write_d   = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a_d = SRCA_OLDPC;
        alu_src_b_d = SRCB_FOUR;
      end
      S_BRANCH: begin
        alu_src_a_d  = SRCA_A;
        alu_op       = ALUOP_BRANCH;
        pc_write_d   = branch_taken;
        instr_done_d = 1'b1;
      end
      S_LUI: begin
        imm_src_d    = IMM_U;
        result_src_d = RES_IMMEXT;
        reg_write_d  = 1'b1;
        instr_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (alu_control_d)
  );

  // Outputs are forced low while reset is held so an aborted instruction
  // cannot issue a write in the reset cycle.
  assign PCWrite    = rst & pc_write_d;
  assign AdrSrc     = rst & adr_src_d;
  assign MemWrite   = rst & mem_write_d;
  assign IRWrite    = rst & ir_write_d;
  assign RegWrite   = rst & reg_write_d;
  assign instr_done = rst & instr_done_d;
  assign ResultSrc  = rst ? result_src_d  : 2'b00;
  assign ALUSrcA    = rst ? alu_src_a_d   : 2'b00;
  assign ALUSrcB    = rst ? alu_src_b_d   : 2'b00;
  assign ALUControl = rst ? alu_control_d : 3'b000;
  assign ImmSrc     = rst ? imm_src_d     : 3'b000;
  assign illegal    = rst & (illegal_q | (state == S_ILLEGAL));
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  import riscv_mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       done, ill;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal;
  logic [3:0] state_dbg;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  bit   ill_sticky = 1'b0;
  rec_t mon_exp, mon_act;

  localparam int ILL_HOLD = 12;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic rec_t sample();
    rec_t r;
    r.st = state_dbg; r.pcw = PCWrite; r.adr = AdrSrc; r.mw = MemWrite;
    r.irw = IRWrite; r.rw = RegWrite; r.rs = ResultSrc; r.sa = ALUSrcA;
    r.sb = ALUSrcB; r.alu = ALUControl; r.imm = ImmSrc; r.done = instr_done;
    r.ill = illegal;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per cycle while out of reset
  always @(negedge clk) begin
    if (rst === 1'b1 && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = sample();
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs state %0d: got %06h required %06h (st pcw adr mw irw rw rs sa sb alu imm done ill) at %0t",
                 mon_exp.st, mon_act, mon_exp, $time);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
                      input logic irw, input logic rw, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                      input logic [2:0] imm, input logic done);
    rec_t r;
    if (st == S_ILLEGAL) ill_sticky = 1'b1;
    r.st = st; r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rw = rw;
    r.rs = rs; r.sa = sa; r.sb = sb; r.alu = alu; r.imm = imm; r.done = done;
    r.ill = ill_sticky;
    exp_q.push_back(r);
  endtask

  function automatic bit legal_ref(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
      OP_RTYPE:  return (f7 == 7'h00 && f3 inside {3'd0, 3'd7, 3'd6, 3'd2}) ||
                        (f7 == 7'h20 && f3 == 3'd0);
      OP_IALU:   return f3 inside {3'd0, 3'd2, 3'd4, 3'd6};
      OP_BRANCH: return f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
      default:   return 1'b0;
    endcase
  endfunction

  // Reference: the per-cycle control word sequence of one instruction
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
    logic [2:0] a;
    logic       tk;
    push(S_FETCH, 1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, ALU_ADD, 3'd0, 0);
    push(S_DECODE, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, ALU_ADD, (op == OP_JAL) ? IMM_J : IMM_B, 0);
    if (!legal_ref(op, f3, f7)) begin
      for (int i = 0; i < ILL_HOLD; i++)
        push(S_ILLEGAL, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
      return;
    end
    case (op)
      OP_LOAD: begin
        push(S_MEMADR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ALU_ADD, IMM_I, 0);
        push(S_MEMREAD, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 0);
        push(S_MEMWB, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      OP_STORE: begin
        push(S_MEMADR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ALU_ADD, IMM_S, 0);
        push(S_MEMWRITE, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      OP_RTYPE: begin
        case (f3)
          3'd7:    a = ALU_AND;
          3'd6:    a = ALU_OR;
          3'd2:    a = ALU_SLT;
          default: a = (f7 == 7'h20) ? ALU_SUB : ALU_ADD;
        endcase
        push(S_EXECR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, a, 3'd0, 0);
        push(S_ALUWB, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      OP_IALU: begin
        case (f3)
          3'd2:    a = ALU_SLT;
          3'd4:    a = ALU_XOR;
          3'd6:    a = ALU_OR;
          default: a = ALU_ADD;
        endcase
        push(S_EXECI, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, a, IMM_I, 0);
        push(S_ALUWB, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      OP_BRANCH: begin
        case (f3)
          3'd0:    tk = z;
          3'd1:    tk = !z;
          3'd4:    tk = !z;
          default: tk = z;
        endcase
        a = (f3 >= 3'd4) ? ALU_SLT : ALU_SUB;
        push(S_BRANCH, tk, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, a, 3'd0, 1);
      end
      OP_JAL: begin
        push(S_JAL, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, ALU_ADD, 3'd0, 0);
        push(S_ALUWB, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      OP_JALR: begin
        push(S_JALR, 1, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1, ALU_ADD, IMM_I, 0);
        push(S_JALRLINK, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, ALU_ADD, 3'd0, 0);
        push(S_ALUWB, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1);
      end
      default: // lui
        push(S_LUI, 0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, ALU_ADD, IMM_U, 1);
    endcase
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    ill_sticky = 1'b0;
    #1;
    check("reset_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
    check("reset_outputs", {8'd0, sample()}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 in FETCH
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
    int n;
    opcode = op; func3 = f3; func7 = f7; zero = z;
    model(op, f3, f7, z);
    n = exp_q.size();
    repeat (n) @(posedge clk);
    #1;
    if (!legal_ref(op, f3, f7)) do_reset(2);
  endtask

  task automatic random_instr();
    logic [2:0] f3;
    logic [6:0] r7;
    logic       z;
    logic [6:0] bad_ops [5];
    logic [2:0] r_f3 [4];
    bad_ops = '{7'b1111111, 7'b0000000, 7'b0010111, 7'b1110011, 7'b0001111};
    r_f3 = '{3'd0, 3'd7, 3'd6, 3'd2};
    r7 = 7'($urandom);
    z  = 1'($urandom);
    f3 = 3'($urandom);
    case ($urandom_range(0, 10))
      0: issue(OP_LOAD, 3'd2, r7, z);
      1: issue(OP_STORE, 3'd2, r7, z);
      2: begin
        f3 = r_f3[$urandom_range(0, 3)];
        issue(OP_RTYPE, f3, (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, z);
      end
      3, 9: issue(OP_IALU, {f3[2:1], 1'b0}, r7, z);
      4, 10: issue(OP_BRANCH, {f3[2], 1'b0, f3[0]}, r7, z);
      5: issue(OP_JAL, f3, r7, z);
      6: issue(OP_JALR, 3'd0, r7, z);
      7: issue(OP_LUI, f3, r7, z);
      default: begin
        case ($urandom_range(0, 4))
          0: issue(bad_ops[$urandom_range(0, 4)], f3, r7, z);
          1: issue(OP_RTYPE, 3'd0, 7'b0000001, z);
          2: issue(OP_RTYPE, 3'd7, 7'h20, z);
          3: issue(OP_BRANCH, {f3[2], 1'b1, f3[0]}, r7, z);
          default: issue(OP_IALU, {f3[2:1], 1'b1}, r7, z);
        endcase
      end
    endcase
  endtask

  initial begin
    rst = 1'b0;
    do_reset(3);
    issue(OP_IALU, 3'd0, 7'h00, 1'b0);
    issue(OP_LOAD, 3'd2, 7'h00, 1'b0);
    issue(OP_STORE, 3'd2, 7'h00, 1'b0);
    issue(OP_BRANCH, 3'd0, 7'h00, 1'b1);
    issue(OP_BRANCH, 3'd0, 7'h00, 1'b0);
    issue(OP_BRANCH, 3'd5, 7'h00, 1'b1);
    issue(OP_BRANCH, 3'd1, 7'h00, 1'b0);
    issue(OP_BRANCH, 3'd4, 7'h00, 1'b1);
    issue(OP_JAL, 3'd0, 7'h00, 1'b0);
    issue(OP_JALR, 3'd0, 7'h00, 1'b0);
    issue(OP_RTYPE, 3'd0, 7'h20, 1'b0);
    issue(OP_LUI, 3'd0, 7'h00, 1'b0);
    issue(7'b1111111, 3'd0, 7'h00, 1'b0);

    // Reset in the middle of a store: MemWrite must drop with rst
    opcode = OP_STORE; func3 = 3'd2; func7 = 7'h00;
    model(OP_STORE, 3'd2, 7'h00, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1;
    check("memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
    check("state_before_reset", {28'd0, state_dbg}, {28'd0, S_MEMWRITE});
    do_reset(2);

    for (int i = 0; i < 120; i++) random_instr();

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
